// File: rtl/tx_pkt_pkg.sv
// Shared types and constants for the USB transmit packet scheduler.
// Holds the FSM state enum, byte/CRC constants, common PIDs and a bit-reflection helper.
package tx_pkt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_DATA,
        ST_CRC_LO,
        ST_CRC_HI,
        ST_EOP
    } state_t;

    localparam logic [7:0]  SYNC_BYTE  = 8'h80;
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;

    function automatic logic [15:0] reflect16(input logic [15:0] v);
        logic [15:0] r;
        r = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            r[i] = v[15 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// Combinational byte-wide CRC16 step, LSB-first reflected form of the USB polynomial.
// The CRC register itself lives in the scheduler.
module usb_crc16
    import tx_pkt_pkg::*;
(
    input  logic [15:0] crc,
    input  logic [7:0]  data,
    output logic [15:0] crc_next
);

    localparam logic [15:0] POLY_REF = reflect16(CRC16_POLY);

    always_comb begin
        crc_next = crc;
        for (int unsigned i = 0; i < 8; i++) begin
            if (crc_next[0] ^ data[i]) begin
                crc_next = (crc_next >> 1) ^ POLY_REF;
            end else begin
                crc_next = crc_next >> 1;
            end
        end
    end

endmodule

// File: rtl/tx_pkt_sched.sv
// USB transmit packet scheduler: arbitrates handshake/data requests and sequences
// SYNC, PID, payload, CRC16 and EOP towards a byte serializer.
module tx_pkt_sched
    import tx_pkt_pkg::*;
(
    input  logic       clk,
    input  logic       nRST,
    input  logic       hs_req,
    input  logic [3:0] hs_pid,
    output logic       hs_gnt,
    input  logic       dt_req,
    input  logic [3:0] dt_pid,
    input  logic       dt_zlp,
    input  logic [7:0] dt_data,
    input  logic       dt_valid,
    input  logic       dt_last,
    output logic       dt_ready,
    output logic       dt_gnt,
    output logic [7:0] byte_data,
    output logic       byte_load,
    input  logic       byte_busy,
    input  logic       byte_done,
    output logic       eop_req,
    input  logic       eop_done,
    output logic       pkt_done,
    output logic       pkt_src,
    output logic       busy
);

    state_t      state, state_next;
    logic        loaded, loaded_next;
    logic        last_q;
    logic [3:0]  pid_q;
    logic        zlp_q;
    logic [15:0] crc_q, crc_calc;

    logic        grant, grant_src, grant_zlp;
    logic [3:0]  grant_pid;
    logic        payload_xfer;
    logic [7:0]  tx_byte;

    usb_crc16 u_crc (
        .crc      (crc_q),
        .data     (dt_data),
        .crc_next (crc_calc)
    );

    always_comb begin
        case (state)
            ST_SYNC:   tx_byte = SYNC_BYTE;
            ST_PID:    tx_byte = {~pid_q, pid_q};
            ST_DATA:   tx_byte = dt_data;
            ST_CRC_LO: tx_byte = ~crc_q[7:0];
            ST_CRC_HI: tx_byte = ~crc_q[15:8];
            default:   tx_byte = '0;
        endcase
    end

    always_comb begin
        state_next   = state;
        loaded_next  = loaded;
        grant        = 1'b0;
        grant_src    = 1'b0;
        grant_pid    = '0;
        grant_zlp    = 1'b0;
        payload_xfer = 1'b0;
        hs_gnt       = 1'b0;
        dt_gnt       = 1'b0;
        dt_ready     = 1'b0;
        byte_load    = 1'b0;
        eop_req      = 1'b0;
        pkt_done     = 1'b0;

        case (state)
            ST_IDLE: begin
                // Grants are gated by nRST so every output stays low while reset is held.
                if (nRST && hs_req) begin
                    grant      = 1'b1;
                    grant_pid  = hs_pid;
                    hs_gnt     = 1'b1;
                    state_next = ST_SYNC;
                end else if (nRST && dt_req) begin
                    grant      = 1'b1;
                    grant_src  = 1'b1;
                    grant_pid  = dt_pid;
                    grant_zlp  = dt_zlp;
                    dt_gnt     = 1'b1;
                    state_next = ST_SYNC;
                end
            end
            ST_DATA: begin
                dt_ready = !loaded && !byte_busy;
                if (dt_ready && dt_valid) begin
                    payload_xfer = 1'b1;
                    byte_load    = 1'b1;
                    loaded_next  = 1'b1;
                end else if (loaded && byte_done) begin
                    loaded_next = 1'b0;
                    if (last_q) begin
                        state_next = ST_CRC_LO;
                    end
                end
            end
            ST_EOP: begin
                eop_req = 1'b1;
                if (eop_done) begin
                    pkt_done   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                if (!loaded && !byte_busy) begin
                    byte_load   = 1'b1;
                    loaded_next = 1'b1;
                end else if (loaded && byte_done) begin
                    loaded_next = 1'b0;
                    case (state)
                        ST_SYNC:   state_next = ST_PID;
                        ST_PID:    state_next = !pkt_src ? ST_EOP :
                                                (zlp_q ? ST_CRC_LO : ST_DATA);
                        ST_CRC_LO: state_next = ST_CRC_HI;
                        default:   state_next = ST_EOP;
                    endcase
                end
            end
        endcase

        byte_data = byte_load ? tx_byte : '0;
        busy      = (state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state   <= ST_IDLE;
            loaded  <= 1'b0;
            last_q  <= 1'b0;
            pid_q   <= '0;
            zlp_q   <= 1'b0;
            pkt_src <= 1'b0;
            crc_q   <= CRC16_INIT;
        end else begin
            state  <= state_next;
            loaded <= loaded_next;
            if (grant) begin
                pid_q   <= grant_pid;
                zlp_q   <= grant_zlp;
                pkt_src <= grant_src;
                crc_q   <= CRC16_INIT;
            end else if (payload_xfer) begin
                crc_q  <= crc_calc;
                last_q <= dt_last;
            end
        end
    end

endmodule
